// File: rtl/tti_rx_queue.sv
// tti_rx_queue
// Receive-side queue between the I3C target controller and the TTI CSR read
// port (RX descriptor or RX data). The controller pushes entries with a
// valid/ready handshake. Firmware pops them through a single-cycle req/ack
// port that never stalls. The block also produces the clamped ready
// threshold and its level trigger, and runs the self-clearing per-queue
// register reset.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   wr_valid_i/wr_ready_o/wr_data_i   push handshake from the controller
//   rd_req_i/rd_ack_o/rd_data_o       CSR pop port (ack 1 cycle after req)
//   ready_thld_i/ready_thld_o         programmed / effective threshold
//   ready_thld_trig_o                 level, count >= effective threshold
//   reg_rst_i                         CSR queue-reset bit
//   reg_rst_we_o/reg_rst_data_o       self-clear write of the reset bit
//   full_o, empty_o, count_o          occupancy status
module tti_rx_queue #(
  parameter int unsigned Depth     = 8,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ThldWidth = 8,
  parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic                 rd_req_i,
  output logic                 rd_ack_o,
  output logic [DataWidth-1:0] rd_data_o,
  input  logic [ThldWidth-1:0] ready_thld_i,
  output logic [ThldWidth-1:0] ready_thld_o,
  output logic                 ready_thld_trig_o,
  input  logic                 reg_rst_i,
  output logic                 reg_rst_we_o,
  output logic                 reg_rst_data_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [CntWidth-1:0]  count_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [ThldWidth-1:0] DepthThld = ThldWidth'(Depth);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RST,
    ST_RST_WAIT
  } state_e;

  state_e state_q, state_d;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrWidth-1:0]  head_q, tail_q;
  logic [CntWidth-1:0]  count_q;
  logic                 rd_ack_q;
  logic [DataWidth-1:0] rd_data_q;
  logic                 push, pop;
  logic [ThldWidth-1:0] thld_eff;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign full_o     = (count_q == CntWidth'(Depth));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign wr_ready_o = !full_o && (state_q == ST_IDLE);

  // A push taken in the same cycle that reg_rst_i is seen is still accepted
  // (the handshake has already completed); the RST state then discards it.
  assign push = wr_valid_i && wr_ready_o;
  // The queue reset request wins over a pop; that read is acked with data 0.
  assign pop  = rd_req_i && (state_q == ST_IDLE) && !reg_rst_i && !empty_o;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (reg_rst_i) state_d = ST_RST;
      ST_RST:      state_d = ST_RST_WAIT;
      ST_RST_WAIT: if (!reg_rst_i) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (state_q == ST_RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= ptr_inc(tail_q);
      if (pop)  head_q <= ptr_inc(head_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntWidth'(1);
        2'b01:   count_q <= count_q - CntWidth'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is intentionally not reset; empty reads return 0 instead.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[tail_q] <= wr_data_i;
  end

  // Every request is acked next cycle; data is the head entry only on a
  // real pop and 0 otherwise, which also clears it the cycle after an ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q  <= rd_req_i;
      rd_data_q <= pop ? mem_q[head_q] : '0;
    end
  end

  assign rd_ack_o  = rd_ack_q;
  assign rd_data_o = rd_data_q;

  always_comb begin
    thld_eff = ready_thld_i;
    if (ready_thld_i == '0)            thld_eff = ThldWidth'(1);
    else if (ready_thld_i > DepthThld) thld_eff = DepthThld;
  end

  assign ready_thld_o      = thld_eff;
  assign ready_thld_trig_o = (ThldWidth'(count_q) >= thld_eff);

  assign reg_rst_we_o   = (state_q == ST_RST);
  assign reg_rst_data_o = 1'b0;

endmodule

// File: doc/tti_rx_queue.md
Name: tti_rx_queue

Overview:
Receive-side queue feeding the TTI CSR read ports (RX descriptor or RX data). The I3C target controller writes into it with a valid/ready handshake. Firmware drains it through the CSR external-register req/ack port. It also produces the ready-threshold trigger and the clamped threshold value, and executes and self-clears the per-queue register reset requested through RESET_CONTROL.

Parameters:
Depth, 8, number of entries (>=2, need not be a power of two)
DataWidth, 32, entry width
ThldWidth, 8, threshold width (must satisfy 2^ThldWidth > Depth)
CntWidth, $clog2(Depth+1), width of the occupancy counter

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
wr_valid_i  input  1  controller has an entry to push
wr_ready_o  output  1  queue accepts the entry this cycle
wr_data_i  input  DataWidth  entry to push
rd_req_i  input  1  single-cycle CSR read request (pop)
rd_ack_o  output  1  single-cycle read acknowledge
rd_data_o  output  DataWidth  read data, valid while rd_ack_o=1
ready_thld_i  input  ThldWidth  threshold programmed in CSR
ready_thld_o  output  ThldWidth  effective (clamped) threshold, written back to CSR
ready_thld_trig_o  output  1  level: occupancy >= effective threshold
reg_rst_i  input  1  CSR queue-reset bit value
reg_rst_we_o  output  1  write enable used to self-clear the CSR reset bit
reg_rst_data_o  output  1  value written to the CSR reset bit (always 0)
full_o  output  1  count == Depth
empty_o  output  1  count == 0
count_o  output  CntWidth  current occupancy

Behaviour:
- Async reset values: pointers=0, count=0, state=IDLE, wr_ready_o=1, rd_ack_o=0, rd_data_o=0, reg_rst_we_o=0, reg_rst_data_o=0, empty_o=1, full_o=0, ready_thld_trig_o=0.
- Storage: circular buffer. Head and tail pointers wrap from Depth-1 to 0. count is a register; full_o, empty_o and count_o are derived from it.
- Push: occurs when wr_valid_i && wr_ready_o. wr_ready_o = !full_o && state==IDLE, so a push is never accepted while the queue is full, even if a pop happens in the same cycle.
- Pop: rd_req_i in IDLE with !empty_o registers the head entry into rd_data_o. rd_ack_o=1 on the next cycle, and the head pointer and count update on that same cycle. Latency from req to ack is exactly 1 cycle.
- Read when empty: rd_ack_o=1 after 1 cycle with rd_data_o=0. No pointer change. The CSR bus never stalls.
- rd_data_o returns to 0 in the cycle after the ack.
- Push and pop resolving in the same cycle leave count unchanged; both pointers advance.
- A rd_req_i arriving in the ack cycle is served normally, giving back-to-back acks on consecutive cycles.
- Threshold clamp (combinational):
  - eff = 1 when ready_thld_i==0.
  - eff = Depth when ready_thld_i > Depth.
  - eff = ready_thld_i otherwise.
  - ready_thld_o = eff.
- ready_thld_trig_o = (count >= eff). It is a level signal computed from the count register and deasserts once pops bring count below eff.
- Reset FSM states: IDLE, RST, RST_WAIT.
  - IDLE -> RST when reg_rst_i=1. This check has priority over rd_req_i and push in the same cycle.
  - RST (1 cycle): pointers and count go to 0, reg_rst_we_o=1, reg_rst_data_o=0. Then -> RST_WAIT.
  - RST_WAIT: hold until reg_rst_i=0, then -> IDLE.
  - In RST and RST_WAIT, wr_ready_o=0 and any rd_req_i is acked 1 cycle later with data 0.
  - A read request coinciding with the entry into RST is acked with data 0.
- Storage contents are not cleared by any reset; only pointers and count are. Reads never expose stale data because empty reads return 0.

Test Plan:
- Reset then 3 pushes (0xA1, 0xA2, 0xA3), then 3 reads -> acks 1 cycle after each req with data 0xA1, 0xA2, 0xA3; count 3->0; empty_o=1 at the end.
- 8 pushes at Depth=8 -> full_o=1, wr_ready_o=0. A 9th valid is held; read plus push in the same cycle -> push rejected, count=7 after the pop; the next cycle the push is accepted. Ten push/pop rounds check pointer wrap, with data order preserved.
- ready_thld_i=3: pushes 1, 2, 3 -> trig 0, 0, 1; one pop -> trig 0. ready_thld_i=0 with 1 entry -> ready_thld_o=1, trig=1. ready_thld_i=200 -> ready_thld_o=8.
- 5 entries queued, reg_rst_i=1 held 3 cycles -> one reg_rst_we_o pulse with data 0, count=0, wr_ready_o=0 until reg_rst_i falls; the next push/read round-trips correctly.
- Read request while empty and while in RST_WAIT -> rd_ack_o after 1 cycle with rd_data_o=0; no count change.
- Assert rst_ni low with 4 entries and an ack pending -> all outputs take their reset values immediately; empty_o=1.
